// File: rtl/uart_dec_rx.sv
// uart_dec_rx: 8N1 UART receiver that parses CR-terminated ASCII decimal
// lines (1..5 digits) into 16-bit values. A good line pulses data_valid with
// the value on data_out; a bad line pulses data_err when its CR arrives.
module uart_dec_rx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        uart_rxd,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        data_err
);

  localparam int BAUD_CNT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W    = $clog2(BAUD_CNT + 1);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(BAUD_CNT / 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BAUD_CNT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {LN_EMPTY, LN_ACC, LN_ERR} ln_state_e;

  logic             rxd_s1_q, rxd_s1_d;
  logic             rxd_s2_q, rxd_s2_d;
  logic [1:0]       settle_q, settle_d;
  logic             rxd_prev_q, rxd_prev_d;
  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  ln_state_e        ln_state_q, ln_state_d;
  logic [16:0]      acc_q, acc_d;
  logic [2:0]       dig_cnt_q, dig_cnt_d;
  logic             ovf_q, ovf_d;
  logic [15:0]      data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             data_err_q, data_err_d;

  logic             fall;
  logic             byte_strobe;
  logic             frame_err;
  logic [7:0]       rx_byte;
  logic             is_digit;
  logic [3:0]       digit;
  logic [19:0]      acc_next;

  // Synchroniser, start-edge detect and bit engine next-state logic.
  always_comb begin
    rxd_s1_d    = uart_rxd;
    rxd_s2_d    = rxd_s1_q;
    settle_d    = {settle_q[0], 1'b1};
    // The edge detector only arms once the synchroniser holds real line
    // data, so a line that is already low at reset release is not a start.
    rxd_prev_d  = settle_q[1] & rxd_s2_q;
    fall        = rxd_prev_q & ~rxd_s2_q;
    rx_state_d  = rx_state_q;
    baud_cnt_d  = baud_cnt_q + 1'b1;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    byte_strobe = 1'b0;
    frame_err   = 1'b0;
    rx_byte     = shift_q;
    case (rx_state_q)
      RX_IDLE: begin
        baud_cnt_d = '0;
        if (fall) rx_state_d = RX_START;
      end
      RX_START: begin
        if (baud_cnt_q == HALF_CNT) begin
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          rx_state_d = rxd_s2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (baud_cnt_q == LAST_CNT) begin
          baud_cnt_d = '0;
          shift_d    = {rxd_s2_q, shift_q[7:1]};
          bit_cnt_d  = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (baud_cnt_q == LAST_CNT) begin
          baud_cnt_d  = '0;
          byte_strobe = rxd_s2_q;
          frame_err   = ~rxd_s2_q;
          rx_state_d  = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Line parser next-state logic; outputs are registered one cycle after the byte.
  always_comb begin
    is_digit     = (rx_byte >= 8'h30) && (rx_byte <= 8'h39);
    digit        = rx_byte[3:0];
    acc_next     = 20'(acc_q) * 20'd10 + 20'(digit);
    ln_state_d   = ln_state_q;
    acc_d        = acc_q;
    dig_cnt_d    = dig_cnt_q;
    ovf_d        = ovf_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    data_err_d   = 1'b0;
    if (frame_err) begin
      ln_state_d = LN_ERR;
    end else if (byte_strobe) begin
      case (ln_state_q)
        LN_EMPTY: begin
          if (is_digit) begin
            acc_d      = 17'(digit);
            dig_cnt_d  = 3'd1;
            ovf_d      = 1'b0;
            ln_state_d = LN_ACC;
          end else if (rx_byte != 8'h0D && rx_byte != 8'h0A) begin
            ln_state_d = LN_ERR;
          end
        end
        LN_ACC: begin
          if (is_digit) begin
            // Saturate so the x10 product can never wrap the accumulator.
            if (acc_next > 20'd65535) begin
              ovf_d = 1'b1;
              acc_d = 17'd65535;
            end else begin
              acc_d = acc_next[16:0];
            end
            dig_cnt_d = (dig_cnt_q == 3'd6) ? 3'd6 : dig_cnt_q + 1'b1;
          end else if (rx_byte == 8'h0D) begin
            if (dig_cnt_q <= 3'd5 && !ovf_q) begin
              data_out_d   = acc_q[15:0];
              data_valid_d = 1'b1;
            end else begin
              data_err_d = 1'b1;
            end
            ln_state_d = LN_EMPTY;
          end else if (rx_byte != 8'h0A) begin
            ln_state_d = LN_ERR;
          end
        end
        LN_ERR: begin
          if (rx_byte == 8'h0D) begin
            data_err_d = 1'b1;
            ln_state_d = LN_EMPTY;
          end
        end
        default: ln_state_d = LN_EMPTY;
      endcase
    end
  end

  // State registers for both FSMs and the registered outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rxd_s1_q     <= 1'b1;
      rxd_s2_q     <= 1'b1;
      settle_q     <= '0;
      rxd_prev_q   <= 1'b0;
      rx_state_q   <= RX_IDLE;
      baud_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      ln_state_q   <= LN_EMPTY;
      acc_q        <= '0;
      dig_cnt_q    <= '0;
      ovf_q        <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      data_err_q   <= 1'b0;
    end else begin
      rxd_s1_q     <= rxd_s1_d;
      rxd_s2_q     <= rxd_s2_d;
      settle_q     <= settle_d;
      rxd_prev_q   <= rxd_prev_d;
      rx_state_q   <= rx_state_d;
      baud_cnt_q   <= baud_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      ln_state_q   <= ln_state_d;
      acc_q        <= acc_d;
      dig_cnt_q    <= dig_cnt_d;
      ovf_q        <= ovf_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      data_err_q   <= data_err_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign data_err   = data_err_q;

endmodule

// File: tb/tb_uart_dec_rx.sv
// Bench for uart_dec_rx: directed lines plus random lines, each checked
// against a string-level model of the line grammar.
module tb_uart_dec_rx;
  localparam int CLK_FREQ  = 2_000_000;
  localparam int BAUD_RATE = 100_000;
  localparam int B = CLK_FREQ / BAUD_RATE;
  localparam int H = B / 2;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        uart_rxd;
  logic [15:0] data_out;
  logic        data_valid;
  logic        data_err;

  uart_dec_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .uart_rxd(uart_rxd),
    .data_out(data_out), .data_valid(data_valid), .data_err(data_err)
  );

  always #5 sys_clk = ~sys_clk;

  int n_vec = 0, n_miss = 0;
  int cyc = 0;
  int n_valid = 0, n_err = 0, n_both = 0, last_valid_cyc = 0;
  int exp_out = 0;
  int cr_t0 = 0;
  logic [7:0] line_q[$];
  bit         bad_q[$];

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    if (data_valid) begin
      n_valid        <= n_valid + 1;
      last_valid_cyc <= cyc;
    end
    if (data_err) n_err <= n_err + 1;
    if (data_valid && data_err) n_both <= n_both + 1;
  end

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_vec++;
    if (obs != exp_v) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic drive_bit(input logic v);
    uart_rxd = v;
    repeat (B) @(posedge sys_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad);
    cr_t0 = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(!bad);
    if (bad) drive_bit(1'b1);
  endtask

  task automatic load(input string s);
    line_q.delete();
    bad_q.delete();
    for (int i = 0; i < s.len(); i++) begin
      line_q.push_back(8'(s[i]));
      bad_q.push_back(1'b0);
    end
  endtask

  // Line outcome from the grammar: 0 = no pulse, 1 = valid value, 2 = error.
  function automatic void model(output int kind, output int val);
    int  nd = 0;
    int  v = 0;
    bit  bad = 0, nondig = 0;
    val = 0;
    foreach (line_q[i]) begin
      if (bad_q[i]) bad = 1;
      else if (line_q[i] == 8'h0A) ;
      else if (line_q[i] >= 8'h30 && line_q[i] <= 8'h39) begin
        nd++;
        if (nd <= 5) v = v * 10 + int'(line_q[i]) - 48;
      end else nondig = 1;
    end
    if (bad || nondig)            kind = 2;
    else if (nd == 0)             kind = 0;
    else if (nd > 5 || v > 65535) kind = 2;
    else begin kind = 1; val = v; end
  endfunction

  task automatic send_line(input string tag);
    int v0, e0, kind, val;
    v0 = n_valid;
    e0 = n_err;
    foreach (line_q[i]) send_byte(line_q[i], bad_q[i]);
    send_byte(8'h0D, 1'b0);
    model(kind, val);
    if (kind == 1) exp_out = val;
    chk({tag, ".valid"}, n_valid - v0, int'(kind == 1));
    chk({tag, ".err"}, n_err - e0, int'(kind == 2));
    chk({tag, ".data_out"}, int'(data_out), exp_out);
    chk({tag, ".both"}, n_both, 0);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: got timeout expected finish");
    n_miss++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $fatal(1, "timeout");
  end

  initial begin
    int lat, v0, e0, len, v;
    uart_rxd  = 1'b1;
    sys_rst_n = 1'b0;
    repeat (5) @(posedge sys_clk);
    #1;
    chk("rst.data_out", int'(data_out), 0);
    chk("rst.valid", int'(data_valid), 0);
    chk("rst.err", int'(data_err), 0);
    sys_rst_n = 1'b1;
    drive_bit(1'b1);
    drive_bit(1'b1);

    load("12345");   send_line("t1");
    lat = last_valid_cyc - cr_t0;
    chk("t1.latency_in_window", int'(lat >= 3 + H + 9 * B && lat <= 5 + H + 9 * B), 1);

    load("65535");   send_line("t2.max");
    load("65536");   send_line("t2.ovf");

    load("00042");   send_line("t3.lead0");
    load("\n");      send_line("t3.lf");
    load("");        send_line("t3.lone_cr");

    load("1a2");     send_line("t4.alpha");
    load("123456");  send_line("t4.six");

    v0 = n_valid;
    e0 = n_err;
    uart_rxd = 1'b0;
    repeat (B / 4) @(posedge sys_clk);
    #1;
    drive_bit(1'b1);
    drive_bit(1'b1);
    chk("t5.glitch_pulses", (n_valid - v0) + (n_err - e0), 0);
    load("7"); bad_q[0] = 1'b1; send_line("t5.framing");
    load("7");                  send_line("t5.good");

    send_byte(8'h39, 1'b0);
    send_byte(8'h38, 1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b1);
    sys_rst_n = 1'b0;
    uart_rxd  = 1'b0;
    @(negedge sys_clk);
    chk("t6.rst_data_out", int'(data_out), 0);
    chk("t6.rst_valid", int'(data_valid), 0);
    chk("t6.rst_err", int'(data_err), 0);
    repeat (10) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    exp_out   = 0;
    repeat (3 * B) @(posedge sys_clk);
    #1;
    drive_bit(1'b1);
    drive_bit(1'b1);
    chk("t6.after_rel_data_out", int'(data_out), 0);
    load("321");     send_line("t6.after_rst");

    for (int n = 0; n < 30; n++) begin
      line_q.delete();
      bad_q.delete();
      if ($urandom_range(0, 4) == 0) begin
        v = int'($urandom_range(64000, 66999));
        for (int k = 10000; k >= 1; k = k / 10) begin
          line_q.push_back(8'(48 + (v / k) % 10));
          bad_q.push_back(1'b0);
        end
      end else begin
        len = int'($urandom_range(0, 7));
        for (int j = 0; j < len; j++) begin
          v = int'($urandom_range(0, 99));
          if (v < 80)      line_q.push_back(8'(48 + $urandom_range(0, 9)));
          else if (v < 88) line_q.push_back(8'h0A);
          else             line_q.push_back(8'($urandom_range(97, 122)));
          bad_q.push_back(1'b0);
        end
      end
      if (line_q.size() > 0 && $urandom_range(0, 9) == 0)
        bad_q[$urandom_range(0, line_q.size() - 1)] = 1'b1;
      send_line($sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
